// File: rtl/data_bus_mmio_if.sv
// Data-side bus between the core (master) and data_bus_mmio (slave).
// Handshake: the master holds data_read/data_write with address, width and
// write data stable until it samples data_busy low; the request is accepted
// on the rising edge where (data_read|data_write) && !data_busy. Requests
// seen while data_busy is high are dropped. data_valid is a one-cycle pulse
// marking data_in as the read result, with no backpressure.
interface data_bus_mmio_if;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_busy;

    modport master (
        output data_address, data_width, data_out, data_read, data_write,
        input  data_in, data_valid, data_busy
    );

    modport slave (
        input  data_address, data_width, data_out, data_read, data_write,
        output data_in, data_valid, data_busy
    );
endinterface

// File: rtl/data_bus_mmio.sv
// Instruction/data RAM with byte-granular access, MMIO debug/timer registers
// and a sticky fault. Word-crossing accesses are split when BUS_UNALIGNED_SPLIT_EN is defined.
module data_bus_mmio #(
    parameter int          MEM_WORDS  = 16384,
    parameter logic [31:0] MMIO_BASE  = 32'h4000_0000,
    parameter int          TIMER_DIV  = 100,
    parameter logic [31:0] NULL_LIMIT = 32'h100
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            instruction_address,
    output logic [31:0]            instruction_data,
    data_bus_mmio_if.slave         bus,
    output logic                   debug_valid,
    output logic [7:0]             debug_char,
    output logic                   timer_irq,
    output logic                   fault,
    output logic [31:0]            fault_addr,
    output logic [1:0]             fsm_state
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_LIMIT = 33'(MEM_WORDS) * 33'd4;
    localparam logic [31:0] PRE_MAX   = 32'(TIMER_DIV - 1);
    localparam logic [31:0] MMIO_SPAN = 32'h1000;

`ifdef BUS_UNALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SPLIT = 2'd1, FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FAULT = 2'd2} state_t;
`endif

    state_t       state;
    logic [31:0]  mem [MEM_WORDS];
    logic [31:0]  timer, prescaler, compare;
    logic         pending;

    logic [31:0]  addr;
    logic [1:0]   lane_o;
    logic [2:0]   n_bytes;
    logic [3:0]   be_n;
    logic [31:0]  wmask, wval, mmio_off, mmio_rd, ram_lo, ram_rd;
    logic [32:0]  end_addr;
    logic [63:0]  wdata64;
    logic [7:0]   be8;
    logic         crossing, is_ram, in_mmio, reg_hit, bad, req;
    logic         ram_we_lo, mmio_we, tick, w1c, match;
    logic [31:0]  timer_nxt, pre_nxt;
    logic [AW-1:0] w_idx, if_idx;

    assign addr      = bus.data_address;
    assign w_idx     = addr[AW+1:2];
    assign if_idx    = instruction_address[AW+1:2];
    assign fsm_state = state;
    assign timer_irq = pending;
    assign req       = (bus.data_read | bus.data_write) && (state == IDLE);

    logic unused_fetch;
    assign unused_fetch = ^{instruction_address[31:AW+2], instruction_address[1:0]};

    // Access decode: span, lane placement and the fault checks.
    always_comb begin
        lane_o = addr[1:0];
        case (bus.data_width)
            2'd0:    begin n_bytes = 3'd1; be_n = 4'b0001; end
            2'd1:    begin n_bytes = 3'd2; be_n = 4'b0011; end
            default: begin n_bytes = 3'd4; be_n = 4'b1111; end
        endcase
        wmask    = {{8{be_n[3]}}, {8{be_n[2]}}, {8{be_n[1]}}, {8{be_n[0]}}};
        wval     = bus.data_out & wmask;
        crossing = ({1'b0, lane_o} + n_bytes) > 3'd4;
        end_addr = {1'b0, addr} + {30'b0, n_bytes} - 33'd1;
        is_ram   = end_addr < RAM_LIMIT;
        mmio_off = addr - MMIO_BASE;
        in_mmio  = !is_ram && (addr >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
        reg_hit  = (mmio_off[1:0] == 2'b00) && (mmio_off <= 32'h10);
        wdata64  = {32'b0, bus.data_out} << {lane_o, 3'b000};
        be8      = {4'b0, be_n} << lane_o;
        bad      = (addr < NULL_LIMIT) || (bus.data_width == 2'd3) ||
                   (bus.data_read && bus.data_write) ||
                   (!is_ram && !in_mmio) || (in_mmio && !reg_hit);
`ifndef BUS_UNALIGNED_SPLIT_EN
        bad      = bad || crossing;
`endif
        ram_lo   = mem[w_idx];
        ram_rd   = (ram_lo >> {lane_o, 3'b000}) & wmask;
        case (mmio_off[4:0])
            5'h08:   mmio_rd = timer & wmask;
            5'h0C:   mmio_rd = compare & wmask;
            5'h10:   mmio_rd = {31'b0, pending};
            default: mmio_rd = 32'h0;
        endcase
        ram_we_lo = req && !bad && is_ram && bus.data_write;
        mmio_we   = req && !bad && in_mmio && bus.data_write;
    end

    // Timer: a TIMER write overrides a same-edge tick; a match beats W1C.
    always_comb begin
        tick      = (prescaler == PRE_MAX);
        pre_nxt   = tick ? 32'h0 : prescaler + 32'h1;
        timer_nxt = tick ? timer + 32'h1 : timer;
        if (mmio_we && mmio_off[4:0] == 5'h08) begin
            timer_nxt = wval;
            pre_nxt   = 32'h0;
        end
        w1c   = mmio_we && (mmio_off[4:0] == 5'h10) && wval[0];
        match = (timer_nxt != timer) && (timer_nxt == compare);
    end

`ifdef BUS_UNALIGNED_SPLIT_EN
    logic          sp_write;
    logic [1:0]    sp_o;
    logic [31:0]   sp_lo, sp_wmask, sp_wdata_hi, ram_hi, split_rd;
    logic [3:0]    sp_be_hi;
    logic [AW-1:0] sp_hi_idx;
    logic [63:0]   merged;

    assign ram_hi   = mem[sp_hi_idx];
    assign merged   = {ram_hi, sp_lo} >> {sp_o, 3'b000};
    assign split_rd = merged[31:0] & sp_wmask;
`else
    logic unused_split;
    assign unused_split = ^{wdata64[63:32], be8[7:4]};
`endif

    // RAM array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (ram_we_lo) begin
            for (int b = 0; b < 4; b++)
                if (be8[b]) mem[w_idx][8*b +: 8] <= wdata64[8*b +: 8];
        end
`ifdef BUS_UNALIGNED_SPLIT_EN
        if (state == SPLIT && sp_write) begin
            for (int b = 0; b < 4; b++)
                if (sp_be_hi[b]) mem[sp_hi_idx][8*b +: 8] <= sp_wdata_hi[8*b +: 8];
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            instruction_data <= 32'h0;
            bus.data_in      <= 32'h0;
            bus.data_valid   <= 1'b0;
            bus.data_busy    <= 1'b0;
            debug_valid      <= 1'b0;
            debug_char       <= 8'h0;
            fault            <= 1'b0;
            fault_addr       <= 32'h0;
            timer            <= 32'h0;
            prescaler        <= 32'h0;
            compare          <= 32'hFFFF_FFFF;
            pending          <= 1'b0;
`ifdef BUS_UNALIGNED_SPLIT_EN
            sp_write         <= 1'b0;
            sp_o             <= 2'b0;
            sp_lo            <= 32'h0;
            sp_wmask         <= 32'h0;
            sp_wdata_hi      <= 32'h0;
            sp_be_hi         <= 4'h0;
            sp_hi_idx        <= '0;
`endif
        end else begin
            instruction_data <= mem[if_idx];
            timer            <= timer_nxt;
            prescaler        <= pre_nxt;
            pending          <= match | (pending & ~w1c);
            bus.data_valid   <= 1'b0;
            debug_valid      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (bad) begin
                            state         <= FAULT;
                            bus.data_busy <= 1'b1;
                            fault         <= 1'b1;
                            fault_addr    <= addr;
                        end
`ifdef BUS_UNALIGNED_SPLIT_EN
                        else if (crossing) begin
                            state         <= SPLIT;
                            bus.data_busy <= 1'b1;
                            sp_write      <= bus.data_write;
                            sp_o          <= lane_o;
                            sp_lo         <= ram_lo;
                            sp_wmask      <= wmask;
                            sp_wdata_hi   <= wdata64[63:32];
                            sp_be_hi      <= be8[7:4];
                            sp_hi_idx     <= w_idx + 1'b1;
                        end
`endif
                        else if (bus.data_read) begin
                            bus.data_valid <= 1'b1;
                            bus.data_in    <= is_ram ? ram_rd : mmio_rd;
                        end else if (in_mmio) begin
                            if (mmio_off[4:0] == 5'h04) begin
                                debug_char  <= bus.data_out[7:0];
                                debug_valid <= 1'b1;
                            end
                            if (mmio_off[4:0] == 5'h0C) compare <= wval;
                        end
                    end
                end
`ifdef BUS_UNALIGNED_SPLIT_EN
                SPLIT: begin
                    state         <= IDLE;
                    bus.data_busy <= 1'b0;
                    if (!sp_write) begin
                        bus.data_in    <= split_rd;
                        bus.data_valid <= 1'b1;
                    end
                end
`endif
                FAULT: state <= FAULT;
                default: begin
                    state         <= IDLE;
                    bus.data_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed bench for data_bus_mmio: RAM lanes, MMIO, timer irq, faults, fetch port.
module tb_data_bus_mmio;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MMIO      = 32'h4000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_address;
    logic [31:0] instruction_data;
    logic        debug_valid;
    logic [7:0]  debug_char;
    logic        timer_irq;
    logic        fault;
    logic [31:0] fault_addr;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int dv_cnt = 0;

    data_bus_mmio_if bus();

    data_bus_mmio #(.MEM_WORDS(MEM_WORDS), .TIMER_DIV(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .instruction_address(instruction_address),
        .instruction_data   (instruction_data),
        .bus                (bus),
        .debug_valid        (debug_valid),
        .debug_char         (debug_char),
        .timer_irq          (timer_irq),
        .fault              (fault),
        .fault_addr         (fault_addr),
        .fsm_state          (fsm_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.data_busy === 1'b1) busy_cnt++;
        if (debug_valid === 1'b1) dv_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_bus();
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_bus();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int guard;
        guard = 0;
        while (bus.data_busy === 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_busy_wait"}, {31'b0, bus.data_busy}, 32'h0);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        @(negedge clock);
        bus.data_address = a;
        bus.data_width   = w;
        bus.data_out     = d;
        bus.data_read    = 1'b0;
        bus.data_write   = 1'b1;
        wait_not_busy("wr");
        @(posedge clock);
        #1 bus.data_write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [1:0] w,
                              input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clock);
        bus.data_address = a;
        bus.data_width   = w;
        bus.data_read    = 1'b1;
        bus.data_write   = 1'b0;
        wait_not_busy(tag);
        @(posedge clock);
        #1 bus.data_read = 1'b0;
        lat = 1;
        while (bus.data_valid !== 1'b1 && lat < 6) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check(tag, bus.data_in, exp);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic fault_case(input string tag, input logic [31:0] a, input logic [1:0] w,
                              input logic rd, input logic wr);
        logic seen_valid;
        pulse_reset();
        @(negedge clock);
        bus.data_address = a;
        bus.data_width   = w;
        bus.data_out     = 32'hDEAD_BEEF;
        bus.data_read    = rd;
        bus.data_write   = wr;
        @(posedge clock);
        #1;
        check({tag, "_fault"}, {31'b0, fault}, 32'h1);
        check({tag, "_addr"}, fault_addr, a);
        check({tag, "_busy"}, {31'b0, bus.data_busy}, 32'h1);
        seen_valid = 1'b0;
        bus.data_address = 32'h44;
        bus.data_width   = 2'd2;
        bus.data_read    = 1'b1;
        bus.data_write   = 1'b0;
        repeat (2) begin @(posedge clock); #1; seen_valid |= bus.data_valid; end
        bus.data_address = 32'h200;
        repeat (2) begin @(posedge clock); #1; seen_valid |= bus.data_valid; end
        check({tag, "_ignored"}, {31'b0, seen_valid}, 32'h0);
        check({tag, "_sticky"}, fault_addr, a);
        check({tag, "_state"}, {30'b0, fsm_state}, 32'h2);
        idle_bus();
    endtask

    logic [31:0] old_w80, w81;
    int b0;

    initial begin
        idle_bus();
        bus.data_address    = 32'h0;
        bus.data_width      = 2'd0;
        bus.data_out        = 32'h0;
        instruction_address = 32'h200;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy",  {31'b0, bus.data_busy}, 32'h0);
        check("rst_valid", {31'b0, bus.data_valid}, 32'h0);
        check("rst_din",   bus.data_in, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_faddr", fault_addr, 32'h0);
        check("rst_irq",   {31'b0, timer_irq}, 32'h0);
        check("rst_dbgv",  {31'b0, debug_valid}, 32'h0);
        check("rst_dbgc",  {24'b0, debug_char}, 32'h0);
        check("rst_idata", instruction_data, 32'h0);
        check("rst_state", {30'b0, fsm_state}, 32'h0);
        reset = 1'b0;

        // Timer: COMPARE=3 written on edge 1, match on edge 12
        bus_write(MMIO + 32'hC, 2'd2, 32'h3);
        repeat (10) @(posedge clock);
        #1 check("irq_edge11", {31'b0, timer_irq}, 32'h0);
        @(posedge clock);
        #1 check("irq_edge12", {31'b0, timer_irq}, 32'h1);
        read_check("status_rd", MMIO + 32'h10, 2'd2, 32'h1, 1);
        read_check("timer_rd", MMIO + 32'h8, 2'd2, 32'h3, 1);
        read_check("compare_rd", MMIO + 32'hC, 2'd2, 32'h3, 1);
        bus_write(MMIO + 32'h10, 2'd2, 32'h1);
        check("irq_w1c", {31'b0, timer_irq}, 32'h0);
        bus_write(MMIO + 32'h8, 2'd2, 32'h2);
        repeat (3) @(posedge clock);
        bus_write(MMIO + 32'h10, 2'd2, 32'h1);
        check("irq_w1c_on_match", {31'b0, timer_irq}, 32'h1);
        read_check("timer_after_load", MMIO + 32'h8, 2'd2, 32'h3, 1);
        bus_write(MMIO + 32'h10, 2'd0, 32'hFFFF_FF01);
        check("irq_clear2", {31'b0, timer_irq}, 32'h0);

        // RAM lanes, no busy on non-crossing accesses
        b0 = busy_cnt;
        bus_write(32'h200, 2'd2, 32'h1122_3344);
        read_check("rd_b201", 32'h201, 2'd0, 32'h33, 1);
        read_check("rd_h202", 32'h202, 2'd1, 32'h1122, 1);
        read_check("rd_w200", 32'h200, 2'd2, 32'h1122_3344, 1);
        read_check("rd_b203", 32'h203, 2'd0, 32'h11, 1);
        bus_write(32'h204, 2'd2, 32'h0);
        bus_write(32'h205, 2'd0, 32'hFFFF_FFA5);
        bus_write(32'h206, 2'd1, 32'h1234_BEEF);
        read_check("rd_w204", 32'h204, 2'd2, 32'hBEEF_A500, 1);
        read_check("rd_h204", 32'h204, 2'd1, 32'h0000_A500, 1);
        bus_write(32'h100, 2'd0, 32'h77);
        read_check("rd_null_limit", 32'h100, 2'd0, 32'h77, 1);
        bus_write(32'hFFC, 2'd2, 32'h1234_5678);
        read_check("rd_top_word", 32'hFFC, 2'd2, 32'h1234_5678, 1);
        check("ram_no_busy", busy_cnt - b0, 32'h0);
        check("ram_no_fault", {31'b0, fault}, 32'h0);

        // MMIO misc
        read_check("mmio_zero", MMIO, 2'd2, 32'h0, 1);
        b0 = dv_cnt;
        bus_write(MMIO + 32'h4, 2'd0, 32'hFFFF_FF41);
        check("dbg_valid", {31'b0, debug_valid}, 32'h1);
        check("dbg_char", {24'b0, debug_char}, 32'h41);
        @(posedge clock);
        #1 check("dbg_valid_drop", {31'b0, debug_valid}, 32'h0);
        check("dbg_pulses", dv_cnt - b0, 32'h1);
        read_check("dbg_rd", MMIO + 32'h4, 2'd2, 32'h0, 1);
        bus_write(MMIO + 32'hC, 2'd1, 32'hFFFF_FFFF);
        read_check("compare_half", MMIO + 32'hC, 2'd2, 32'h0000_FFFF, 1);
        read_check("compare_byte", MMIO + 32'hC, 2'd0, 32'h0000_00FF, 1);

`ifdef BUS_UNALIGNED_SPLIT_EN
        b0 = busy_cnt;
        bus_write(32'h203, 2'd2, 32'hAABB_CCDD);
        @(posedge clock);
        #1 check("split_wr_busy", busy_cnt - b0, 32'h1);
        read_check("split_w80", 32'h200, 2'd2, 32'hDD22_3344, 1);
        read_check("split_w81", 32'h204, 2'd2, 32'hBEAA_BBCC, 1);
        b0 = busy_cnt;
        read_check("split_rd", 32'h203, 2'd2, 32'hAABB_CCDD, 2);
        check("split_rd_busy", busy_cnt - b0, 32'h1);
        read_check("split_rd_half", 32'h203, 2'd1, 32'h0000_CCDD, 2);
        old_w80 = 32'hDD22_3344;
        w81     = 32'hBEAA_BBCC;
`else
        old_w80 = 32'h1122_3344;
        w81     = 32'hBEEF_A500;
`endif

        // Fetch port: same-edge write returns the old word
        @(posedge clock);
        #1 check("if_before", instruction_data, old_w80);
        bus_write(32'h200, 2'd2, 32'hCAFE_F00D);
        check("if_same_edge", instruction_data, old_w80);
        @(posedge clock);
        #1 check("if_next", instruction_data, 32'hCAFE_F00D);
        instruction_address = 32'h200 + MEM_WORDS * 4;
        @(posedge clock);
        #1 check("if_wrap", instruction_data, 32'hCAFE_F00D);
        instruction_address = 32'h204;
        @(posedge clock);
        #1 check("if_w81", instruction_data, w81);

`ifdef BUS_UNALIGNED_SPLIT_EN
        @(negedge clock);
        bus.data_address = 32'h203;
        bus.data_width   = 2'd2;
        bus.data_read    = 1'b1;
        @(posedge clock);
        #1 idle_bus();
        check("mid_split_state", {30'b0, fsm_state}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("mid_split_rst_busy", {31'b0, bus.data_busy}, 32'h0);
        check("mid_split_rst_state", {30'b0, fsm_state}, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
`endif

        // Fault sources, each from a fresh reset
        fault_case("null", 32'h40, 2'd2, 1'b1, 1'b0);
        fault_case("null_edge", 32'hFF, 2'd0, 1'b1, 1'b0);
        fault_case("ram_end", MEM_WORDS * 4, 2'd2, 1'b1, 1'b0);
        fault_case("mmio_hole", MMIO + 32'h14, 2'd2, 1'b1, 1'b0);
        fault_case("mmio_lane", MMIO + 32'h9, 2'd0, 1'b1, 1'b0);
        fault_case("width3", 32'h200, 2'd3, 1'b1, 1'b0);
        fault_case("rd_wr", 32'h200, 2'd2, 1'b1, 1'b1);
`ifndef BUS_UNALIGNED_SPLIT_EN
        fault_case("split_off", 32'h203, 2'd2, 1'b0, 1'b1);
`endif
        fault_case("ram_tail", 32'hFFE, 2'd2, 1'b0, 1'b1);

        #2 reset = 1'b1;
        #1;
        check("fault_rst_busy", {31'b0, bus.data_busy}, 32'h0);
        check("fault_rst_fault", {31'b0, fault}, 32'h0);
        check("fault_rst_faddr", fault_addr, 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        read_check("post_fault_ffc", 32'hFFC, 2'd2, 32'h1234_5678, 1);
        read_check("post_fault_200", 32'h200, 2'd2, 32'hCAFE_F00D, 1);
        read_check("post_fault_204", 32'h204, 2'd2, w81, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
